// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter/baud-config bundle for the UART TX arbiter.
// The master side is the arbiter; the slave side is its environment.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        cfg_valid;
    logic [1:0]  cfg_baud;
    logic        cfg_ready;
    logic [1:0]  baud_select;
    logic        gen_reset_n;
    logic        timeout_err;

    modport master (
        input  req, req_data, tx_busy, cfg_valid, cfg_baud,
        output grant, tx_data, tx_start, cfg_ready,
               baud_select, gen_reset_n, timeout_err
    );

    modport slave (
        output req, req_data, tx_busy, cfg_valid, cfg_baud,
        input  grant, tx_data, tx_start, cfg_ready,
               baud_select, gen_reset_n, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte
// requesters, with baud reconfiguration and busy-handshake timeout.
module uart_tx_arbiter #(
    parameter int SETTLE_CYCLES = 16,
    parameter int BUSY_TIMEOUT  = 64
) (
    input logic              clk,
    input logic              reset_n,
    uart_tx_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CFG_HOLD  = 3'd4;

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [1:0] r_last;
    logic [3:0] r_grant;
    logic [7:0] r_tx_data;
    logic       r_tx_start;
    logic       r_timeout;
    logic [1:0] r_baud;
    logic       r_gen_rst_n;

    logic       w_cfg_ready;
    logic       w_cfg_take;
    logic       w_grant_take;
    logic       w_pick_vld;
    logic [1:0] w_pick_idx;

    assign w_cfg_ready  = (r_state == S_IDLE) && !bus.tx_busy;
    assign w_cfg_take   = w_cfg_ready && bus.cfg_valid;
    assign w_grant_take = w_cfg_ready && !bus.cfg_valid && w_pick_vld;

    // Walk downward so the candidate nearest after r_last wins last.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[r_last + 2'(k)]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = r_last + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 2'd3;
            r_grant     <= 4'd0;
            r_tx_data   <= 8'd0;
            r_tx_start  <= 1'b0;
            r_timeout   <= 1'b0;
            r_baud      <= 2'd0;
            r_gen_rst_n <= 1'b0;
        end else begin
            r_grant     <= 4'd0;
            r_tx_start  <= 1'b0;
            r_timeout   <= 1'b0;
            r_gen_rst_n <= 1'b1;
            unique case (1'b1)
                (r_state == S_IDLE): begin
                    if (w_cfg_take) begin
                        r_baud      <= bus.cfg_baud;
                        r_gen_rst_n <= 1'b0;
                        r_cnt       <= 8'(SETTLE_CYCLES);
                        r_state     <= S_CFG_HOLD;
                    end else if (w_grant_take) begin
                        r_grant   <= 4'b0001 << w_pick_idx;
                        r_tx_data <= bus.req_data[8*w_pick_idx +: 8];
                        r_last    <= w_pick_idx;
                        r_state   <= S_ISSUE;
                    end
                end
                (r_state == S_ISSUE): begin
                    r_tx_start <= 1'b1;
                    r_cnt      <= 8'(BUSY_TIMEOUT);
                    r_state    <= S_WAIT_BUSY;
                end
                (r_state == S_WAIT_BUSY): begin
                    if (bus.tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt <= 8'd1) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                (r_state == S_WAIT_DONE): begin
                    if (!bus.tx_busy)
                        r_state <= S_IDLE;
                end
                (r_state == S_CFG_HOLD): begin
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt <= 8'd1)
                        r_state <= S_IDLE;
                    else
                        r_gen_rst_n <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_start    = r_tx_start;
    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.baud_select = r_baud;
    assign bus.gen_reset_n = r_gen_rst_n;
    assign bus.timeout_err = r_timeout;
endmodule
